// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for a shared combinational ALU.
// Operands are registered and held, and the ALU result comes back through a single-entry response register.
module alu_arbiter #(
  parameter int N       = 32,
  parameter int MUL_LAT = 2
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_op1,
  input  logic [N-1:0] req0_op2,
  input  logic [2:0]   req0_sel,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_op1,
  input  logic [N-1:0] req1_op2,
  input  logic [2:0]   req1_sel,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp_q,
  output logic [N-1:0] alu_op1,
  output logic [N-1:0] alu_op2,
  output logic [2:0]   alu_sel,
  input  logic [N-1:0] alu_q,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_e;

  localparam logic [2:0] SelMul = 3'd2;
  localparam logic [3:0] MulCnt = 4'(MUL_LAT - 1);

  state_e         state_q, state_d;
  logic           prio_q, prio_d;
  logic           id_q, id_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [N-1:0]   op1_q, op1_d;
  logic [N-1:0]   op2_q, op2_d;
  logic [2:0]     sel_q, sel_d;
  logic [N-1:0]   rsp_data_q, rsp_data_d;
  logic           grant0, grant1;

  // prio_q == 1 means port 1 wins a tie
  assign grant0 = req0_valid && (!req1_valid || !prio_q);
  assign grant1 = req1_valid && (!req0_valid ||  prio_q);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      id_q       <= 1'b0;
      cnt_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      sel_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      sel_q      <= sel_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    sel_d      = sel_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          id_d    = grant1;
          op1_d   = grant1 ? req1_op1 : req0_op1;
          op2_d   = grant1 ? req1_op2 : req0_op2;
          sel_d   = grant1 ? req1_sel : req0_sel;
          cnt_d   = (sel_d == SelMul) ? MulCnt : 4'd0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_data_d = alu_q;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        // Only the owning port's consumer can release the response register
        if (id_q ? rsp1_ready : rsp0_ready) begin
          prio_d  = ~id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = n_reset && (state_q == IDLE) && grant0;
    req1_ready = n_reset && (state_q == IDLE) && grant1;
    rsp0_valid = (state_q == HOLD) && !id_q;
    rsp1_valid = (state_q == HOLD) &&  id_q;
    busy       = (state_q != IDLE);
    rsp_q      = rsp_data_q;
    alu_op1    = op1_q;
    alu_op2    = op2_q;
    alu_sel    = sel_q;
  end

endmodule
